// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, IV, FSM encoding, round and
// padding helpers. Define SHA256_UNROLL2_EN to build the two-rounds-per-cycle
// variant; the default build does one round per cycle.
package sha256_pkg;

`ifdef SHA256_UNROLL2_EN
  localparam int unsigned RPC = 2;
`else
  localparam int unsigned RPC = 1;
`endif

  localparam int unsigned SHA256_BLOCK_BYTES = 64;
  localparam int unsigned WORD_W             = 32;
  localparam int unsigned BLOCK_W            = 512;
  localparam int unsigned STATE_W            = 256;
  localparam int unsigned RND_CYCLES         = 64 / RPC;

  localparam logic [STATE_W-1:0] IV_256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [WORD_W-1:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RND  = 3'd2,
    ST_ADD  = 3'd3,
    ST_DONE = 3'd4
  } sha256_fsm_t;

  // Working variables a..h, a in the top word to match the H0-first layout.
  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
    logic [WORD_W-1:0] e;
    logic [WORD_W-1:0] f;
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] h;
  } sha256_vars_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // One compression round; all additions wrap modulo 2^32.
  function automatic sha256_vars_t sha256_round(input sha256_vars_t v,
                                                input logic [31:0] k,
                                                input logic [31:0] w);
    logic [31:0] t1;
    logic [31:0] t2;
    sha256_vars_t r;
    t1  = v.h + big_sigma1(v.e) + ch(v.e, v.f, v.g) + k + w;
    t2  = big_sigma0(v.a) + maj(v.a, v.b, v.c);
    r.h = v.g;
    r.g = v.f;
    r.f = v.e;
    r.e = v.d + t1;
    r.d = v.c;
    r.c = v.b;
    r.b = v.a;
    r.a = t1 + t2;
    return r;
  endfunction

  // Builds {block1, block2} for a final request carrying len (0..64) bytes.
  // block2 is only meaningful when len >= 56.
  function automatic logic [1023:0] sha256_pad(input logic [511:0] data,
                                               input logic [6:0]   len,
                                               input logic [63:0]  bitlen);
    logic [511:0] b1;
    logic [511:0] b2;
    b1 = '0;
    b2 = '0;
    for (int i = 0; i < 64; i++) begin
      if (7'(i) < len) begin
        b1[511-8*i -: 8] = data[511-8*i -: 8];
      end else if (7'(i) == len) begin
        b1[511-8*i -: 8] = 8'h80;
      end
    end
    if (len <= 7'd55) begin
      b1[63:0] = bitlen;
    end else begin
      b2[63:0] = bitlen;
      if (len == 7'd64) begin
        b2[511:504] = 8'h80;
      end
    end
    return {b1, b2};
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: 16-word W window, loaded from a block and shifted
// by RPC words per round cycle (RPC=2 when SHA256_UNROLL2_EN is defined).
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     shift,
  input  logic [BLOCK_W-1:0]       block,
  output logic [RPC-1:0][WORD_W-1:0] w
);

  logic [WORD_W-1:0] w_q [16];
  logic [RPC-1:0][WORD_W-1:0] nxt_c;

  // Next schedule words W[t+16+j] from the current window.
  always_comb begin
    nxt_c = '0;
    for (int j = 0; j < int'(RPC); j++) begin
      nxt_c[j] = small_sigma1(w_q[14+j]) + w_q[9+j] + small_sigma0(w_q[1+j]) + w_q[j];
    end
  end

  // Current round words are the head of the window.
  always_comb begin
    w = '0;
    for (int j = 0; j < int'(RPC); j++) begin
      w[j] = w_q[j];
    end
  end

  // Window register: parallel load, or shift in the freshly generated words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= block[511-32*i -: 32];
      end
    end else if (shift) begin
      for (int i = 0; i < 16 - int'(RPC); i++) begin
        w_q[i] <= w_q[i+int'(RPC)];
      end
      for (int j = 0; j < int'(RPC); j++) begin
        w_q[16-int'(RPC)+j] <= nxt_c[j];
      end
    end
  end

endmodule

// File: rtl/sha256_inc_core.sv
// Incremental SHA-256 compression core with built-in final-block padding and a
// running message byte counter. SHA256_UNROLL2_EN selects two rounds per cycle.
module sha256_inc_core
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sha256_start,
  input  logic               sha256_1st,
  input  logic               sha256_final,
  input  logic [STATE_W-1:0] sha256_state,
  input  logic [BLOCK_W-1:0] sha256_data,
  input  logic [6:0]         sha256_len,
  output logic               sha256_done,
  output logic [STATE_W-1:0] sha256_dout,
  output logic               busy
);

  sha256_fsm_t state_q, state_d;
  logic cap_c, load_c, rnd_c, add_c;

  logic [STATE_W-1:0]   h_q;
  logic [BLOCK_W-1:0]   data_q;
  logic [6:0]           len_q;
  logic                 first_q;
  logic                 final_q;
  logic                 blk_sel_q;
  logic [5:0]           rnd_cnt_q;
  logic [LEN_CNT_W-1:0] cnt_q;
  sha256_vars_t         v_q;

  logic [6:0]             len_sat_c;
  logic [LEN_CNT_W-1:0]   cnt_next_c;
  logic [63:0]            bitlen_c;
  logic [1023:0]          pad_c;
  logic [BLOCK_W-1:0]     blk_c;
  logic                   two_blk_c;
  logic                   last_rnd_c;
  logic [STATE_W-1:0]     h_sum_c;
  sha256_vars_t           v_rnd_c;
  logic [RPC-1:0][WORD_W-1:0] w_c;

  assign len_sat_c  = (sha256_len > 7'd64) ? 7'd64 : sha256_len;
  assign two_blk_c  = final_q && (len_q >= 7'd56);
  assign last_rnd_c = (rnd_cnt_q == 6'(RND_CYCLES - 1));

  // Byte counter after this request; bit length for block2 uses the already
  // committed counter since it was updated at the block1 load.
  assign cnt_next_c = (first_q ? '0 : cnt_q) +
                      (final_q ? LEN_CNT_W'(len_q) : LEN_CNT_W'(SHA256_BLOCK_BYTES));
  assign bitlen_c   = 64'({(blk_sel_q ? cnt_q : cnt_next_c), 3'b000});
  assign pad_c      = sha256_pad(data_q, len_q, bitlen_c);
  assign blk_c      = !final_q ? data_q : (blk_sel_q ? pad_c[511:0] : pad_c[1023:512]);

  sha256_msg_sched u_sched (
    .clk   (clk),
    .rst   (rst),
    .load  (load_c),
    .shift (rnd_c),
    .block (blk_c),
    .w     (w_c)
  );

  // RPC rounds applied back to back in one cycle.
  always_comb begin
    v_rnd_c = v_q;
    for (int r = 0; r < int'(RPC); r++) begin
      v_rnd_c = sha256_round(v_rnd_c, SHA256_K[6'(int'(rnd_cnt_q) * int'(RPC) + r)], w_c[r]);
    end
  end

  // Feed-forward addition of the working variables into the chaining value.
  always_comb begin
    logic [STATE_W-1:0] v_flat;
    v_flat  = v_q;
    h_sum_c = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum_c[255-32*i -: 32] = h_q[255-32*i -: 32] + v_flat[255-32*i -: 32];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and datapath strobes.
  always_comb begin
    state_d = state_q;
    cap_c   = 1'b0;
    load_c  = 1'b0;
    rnd_c   = 1'b0;
    add_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sha256_start) begin
          cap_c   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_c  = 1'b1;
        state_d = ST_RND;
      end
      ST_RND: begin
        rnd_c = 1'b1;
        if (last_rnd_c) begin
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        add_c   = 1'b1;
        state_d = (two_blk_c && !blk_sel_q) ? ST_LOAD : ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request capture, round datapath, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q         <= '0;
      data_q      <= '0;
      len_q       <= '0;
      first_q     <= 1'b0;
      final_q     <= 1'b0;
      blk_sel_q   <= 1'b0;
      rnd_cnt_q   <= '0;
      cnt_q       <= '0;
      v_q         <= '0;
      sha256_done <= 1'b0;
      sha256_dout <= '0;
      busy        <= 1'b0;
    end else begin
      sha256_done <= 1'b0;
      if (cap_c) begin
        h_q       <= sha256_state;
        data_q    <= sha256_data;
        len_q     <= len_sat_c;
        first_q   <= sha256_1st;
        final_q   <= sha256_final;
        blk_sel_q <= 1'b0;
        busy      <= 1'b1;
      end
      if (load_c) begin
        v_q       <= h_q;
        rnd_cnt_q <= '0;
        if (!blk_sel_q) begin
          cnt_q <= cnt_next_c;
        end
      end
      if (rnd_c) begin
        v_q       <= v_rnd_c;
        rnd_cnt_q <= rnd_cnt_q + 6'd1;
      end
      if (add_c) begin
        h_q <= h_sum_c;
        if (two_blk_c && !blk_sel_q) begin
          blk_sel_q <= 1'b1;
        end else begin
          sha256_done <= 1'b1;
          sha256_dout <= h_sum_c;
          busy        <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_inc_core.sv
// Directed self-checking bench for sha256_inc_core using known SHA-256 vectors.
module tb_sha256_inc_core;

`ifdef SHA256_UNROLL2_EN
  localparam int LAT1 = 35;
  localparam int LAT2 = 69;
`else
  localparam int LAT1 = 67;
  localparam int LAT2 = 133;
`endif

  localparam logic [255:0] IV   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_56 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_64A = 256'hffe054fe7ae0cb6dc65c3af9b61d5209f439851db43d0ba5997337df154668eb;

  logic         clk;
  logic         rst;
  logic         sha256_start;
  logic         sha256_1st;
  logic         sha256_final;
  logic [255:0] sha256_state;
  logic [511:0] sha256_data;
  logic [6:0]   sha256_len;
  logic         sha256_done;
  logic [255:0] sha256_dout;
  logic         busy;

  int checks;
  int errors;

  logic [511:0] blk_abc;
  logic [511:0] blk_56;
  logic [511:0] blk_64a;
  logic [447:0] str_56;

  sha256_inc_core dut (
    .clk          (clk),
    .rst          (rst),
    .sha256_start (sha256_start),
    .sha256_1st   (sha256_1st),
    .sha256_final (sha256_final),
    .sha256_state (sha256_state),
    .sha256_data  (sha256_data),
    .sha256_len   (sha256_len),
    .sha256_done  (sha256_done),
    .sha256_dout  (sha256_dout),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for done; cyc is the cycle of done.
  task automatic run_req(input logic [255:0] st, input logic [511:0] dt,
                         input logic [6:0] ln, input logic fst, input logic fin,
                         output logic [255:0] res, output int cyc,
                         output logic busy1, output logic busyd);
    sha256_state = st;
    sha256_data  = dt;
    sha256_len   = ln;
    sha256_1st   = fst;
    sha256_final = fin;
    sha256_start = 1'b1;
    tick();
    sha256_start = 1'b0;
    cyc   = 1;
    busy1 = busy;
    while (!sha256_done && cyc < 400) begin
      tick();
      cyc++;
    end
    res   = sha256_dout;
    busyd = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (sha256_done !== 1'b0 || busy !== 1'b0 || sha256_dout !== 256'h0) begin
      errors++;
      $display("FAIL reset_in: done=%b busy=%b dout=%h required 0/0/0", sha256_done, busy, sha256_dout);
    end
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (sha256_done !== 1'b0 || busy !== 1'b0 || sha256_dout !== 256'h0) begin
      errors++;
      $display("FAIL reset_out: done=%b busy=%b dout=%h required 0/0/0", sha256_done, busy, sha256_dout);
    end
  endtask

  task automatic test_abc();
    logic [255:0] res;
    int cyc;
    logic b1, bd;
    run_req(IV, blk_abc, 7'd3, 1'b1, 1'b1, res, cyc, b1, bd);
    checks++;
    if (res !== D_ABC) begin
      errors++;
      $display("FAIL abc_digest: got %h required %h", res, D_ABC);
    end
    checks++;
    if (cyc !== LAT1) begin
      errors++;
      $display("FAIL abc_latency: got %0d required %0d", cyc, LAT1);
    end
    checks++;
    if (b1 !== 1'b1 || bd !== 1'b0) begin
      errors++;
      $display("FAIL abc_busy: cycle1=%b done_cycle=%b required 1/0", b1, bd);
    end
    tick();
    checks++;
    if (sha256_done !== 1'b0 || sha256_dout !== D_ABC) begin
      errors++;
      $display("FAIL abc_hold: done=%b dout=%h required 0 and %h", sha256_done, sha256_dout, D_ABC);
    end
  endtask

  // Start issued in the IDLE cycle right after DONE.
  task automatic test_back_to_back();
    logic [255:0] res;
    int cyc;
    logic b1, bd;
    run_req(IV, 512'h0, 7'd0, 1'b1, 1'b1, res, cyc, b1, bd);
    checks++;
    if (res !== D_EMPTY) begin
      errors++;
      $display("FAIL empty_digest: got %h required %h", res, D_EMPTY);
    end
    checks++;
    if (cyc !== LAT1) begin
      errors++;
      $display("FAIL empty_latency: got %0d required %0d", cyc, LAT1);
    end
    tick();
  endtask

  task automatic test_two_block();
    logic [255:0] res;
    int cyc;
    logic b1, bd;
    run_req(IV, blk_56, 7'd56, 1'b1, 1'b1, res, cyc, b1, bd);
    checks++;
    if (res !== D_56) begin
      errors++;
      $display("FAIL len56_digest: got %h required %h", res, D_56);
    end
    checks++;
    if (cyc !== LAT2) begin
      errors++;
      $display("FAIL len56_latency: got %0d required %0d", cyc, LAT2);
    end
    tick();
  endtask

  task automatic test_incremental();
    logic [255:0] mid;
    logic [255:0] res;
    int cyc;
    logic b1, bd;
    run_req(IV, blk_64a, 7'd0, 1'b1, 1'b0, mid, cyc, b1, bd);
    checks++;
    if (cyc !== LAT1) begin
      errors++;
      $display("FAIL incr_blk1_latency: got %0d required %0d", cyc, LAT1);
    end
    tick();
    run_req(mid, 512'h0, 7'd0, 1'b0, 1'b1, res, cyc, b1, bd);
    checks++;
    if (res !== D_64A) begin
      errors++;
      $display("FAIL incr_digest: got %h required %h", res, D_64A);
    end
    checks++;
    if (cyc !== LAT1) begin
      errors++;
      $display("FAIL incr_blk2_latency: got %0d required %0d", cyc, LAT1);
    end
    tick();
  endtask

  // len=64 puts 0x80 in block2; len above 64 saturates to the same result.
  task automatic test_len64();
    logic [255:0] res;
    int cyc;
    logic b1, bd;
    run_req(IV, blk_64a, 7'd64, 1'b1, 1'b1, res, cyc, b1, bd);
    checks++;
    if (res !== D_64A) begin
      errors++;
      $display("FAIL len64_digest: got %h required %h", res, D_64A);
    end
    checks++;
    if (cyc !== LAT2) begin
      errors++;
      $display("FAIL len64_latency: got %0d required %0d", cyc, LAT2);
    end
    tick();
    run_req(IV, blk_64a, 7'd100, 1'b1, 1'b1, res, cyc, b1, bd);
    checks++;
    if (res !== D_64A) begin
      errors++;
      $display("FAIL len100_digest: got %h required %h", res, D_64A);
    end
    tick();
  endtask

  task automatic test_busy_start();
    int cyc;
    int ndone;
    int first_cyc;
    logic [255:0] res;
    ndone     = 0;
    first_cyc = -1;
    res       = '0;
    sha256_state = IV;
    sha256_data  = blk_abc;
    sha256_len   = 7'd3;
    sha256_1st   = 1'b1;
    sha256_final = 1'b1;
    sha256_start = 1'b1;
    tick();
    sha256_start = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 10) begin
        sha256_data  = 512'h0;
        sha256_len   = 7'd0;
        sha256_start = 1'b1;
      end
      if (cyc == 11) begin
        sha256_start = 1'b0;
      end
      if (sha256_done === 1'b1) begin
        ndone++;
        if (first_cyc < 0) begin
          first_cyc = cyc;
          res       = sha256_dout;
        end
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL busy_start_done_count: got %0d required 1", ndone);
    end
    checks++;
    if (first_cyc !== LAT1 || res !== D_ABC) begin
      errors++;
      $display("FAIL busy_start_result: cycle %0d dout %h required cycle %0d dout %h",
               first_cyc, res, LAT1, D_ABC);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int ndone;
    logic [255:0] res;
    logic b1, bd;
    sha256_state = IV;
    sha256_data  = blk_abc;
    sha256_len   = 7'd3;
    sha256_1st   = 1'b1;
    sha256_final = 1'b1;
    sha256_start = 1'b1;
    tick();
    sha256_start = 1'b0;
    cyc = 1;
    while (cyc < 30) begin
      tick();
      cyc++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (sha256_done !== 1'b0 || sha256_dout !== 256'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: done=%b busy=%b dout=%h required 0/0/0", sha256_done, busy, sha256_dout);
    end
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sha256_done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: got %0d done pulses required 0", ndone);
    end
    run_req(IV, blk_abc, 7'd3, 1'b1, 1'b1, res, cyc, b1, bd);
    checks++;
    if (res !== D_ABC || cyc !== LAT1) begin
      errors++;
      $display("FAIL after_reset_abc: dout %h cycle %0d required %h cycle %0d", res, cyc, D_ABC, LAT1);
    end
    tick();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    sha256_start = 1'b0;
    sha256_1st   = 1'b0;
    sha256_final = 1'b0;
    sha256_state = '0;
    sha256_data  = '0;
    sha256_len   = '0;
    blk_abc      = {24'h616263, 488'h0};
    str_56       = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    blk_56       = {str_56, 64'h0};
    blk_64a      = {64{8'h61}};

    test_reset();
    test_abc();
    test_back_to_back();
    test_two_block();
    test_incremental();
    test_len64();
    test_busy_start();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
